// File: rtl/pll_rst_pkg.sv
// Shared types and default constants for the PLL reset / clock-enable generator.
package pll_rst_pkg;

  // Sequencer states; the encoding is exported on state_o for debug.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_LOCK_STABLE = 1024;
  localparam int DEFAULT_RESET_HOLD  = 16;
  localparam int DEFAULT_CE_DIV      = 4;
  localparam int DEFAULT_AUDIO_DIV   = 192;
  localparam int DEFAULT_LOSS_W      = 8;

  // Larger of two integers, used to size the shared STABLE/HOLD counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Single-cycle clock-enable generator: one pulse every DIV cycles while en is high.
// The phase counter is held at zero whenever en is low, so every enable
// window starts with a fresh phase and the first pulse lands on cycle DIV-1.
module ce_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic ce
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  // Phase counter: cleared outside the enable window, wraps at DIV-1 inside it.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign ce = en && (cnt_q == LAST);

endmodule

// File: rtl/pll_reset_ce_gen.sv
// System reset sequencer and clock-enable generator driven by the PLL lock flag.
// Lock must be seen continuously for the stability window, then the reset is
// held a little longer before downstream logic is released into RUN.
module pll_reset_ce_gen
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int LOCK_STABLE = DEFAULT_LOCK_STABLE,
  parameter int RESET_HOLD  = DEFAULT_RESET_HOLD,
  parameter int CE_DIV      = DEFAULT_CE_DIV,
  parameter int AUDIO_DIV   = DEFAULT_AUDIO_DIV,
  parameter int LOSS_W      = DEFAULT_LOSS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              sys_rst,
  output logic              ready,
  output logic              ce_pix,
  output logic              ce_48k,
  output logic [LOSS_W-1:0] lock_loss_cnt,
  output logic [1:0]        state_o
);

  // The shared counter must reach LOCK_STABLE-1 in STABLE and RESET_HOLD in HOLD.
  // HOLD runs one cycle past RESET_HOLD-1 so that release lands exactly
  // SYNC_STAGES+1+LOCK_STABLE+RESET_HOLD edges after lock is first sampled.
  localparam int CNT_W = $clog2(max_int(LOCK_STABLE, RESET_HOLD + 1));
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  pll_state_t             state_q;
  pll_state_t             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [LOSS_W-1:0]      loss_q;
  logic                   run_en;

  // Bring the asynchronous lock flag into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State and shared STABLE/HOLD counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: any low sample of the synchronized lock restarts the sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Count lock losses that tear down RUN; earlier drops are just part of acquisition.
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q <= '0;
    end else if ((state_q == RUN) && !locked_s && (loss_q != {LOSS_W{1'b1}})) begin
      loss_q <= loss_q + LOSS_W'(1);
    end
  end

  assign run_en        = (state_q == RUN);
  assign sys_rst       = !run_en;
  assign ready         = run_en;
  assign state_o       = state_q;
  assign lock_loss_cnt = loss_q;

  ce_divider #(
    .DIV(CE_DIV)
  ) u_ce_pix (
    .clk(clk),
    .rst(rst),
    .en (run_en),
    .ce (ce_pix)
  );

  ce_divider #(
    .DIV(AUDIO_DIV)
  ) u_ce_48k (
    .clk(clk),
    .rst(rst),
    .en (run_en),
    .ce (ce_48k)
  );

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Self-checking bench for pll_reset_ce_gen with a small lock-sequence model and scoreboard.
module tb_pll_reset_ce_gen;

  localparam int L_STABLE = 8;
  localparam int R_HOLD   = 4;
  localparam int PIX_DIV  = 4;
  localparam int AUD_DIV  = 192;
  // Consecutive locked_s samples (at FSM edges) needed to be in RUN.
  localparam int RUN_K    = L_STABLE + R_HOLD + 2;

  typedef struct packed {
    logic       sys_rst;
    logic       ready;
    logic       ce_pix;
    logic       ce_48k;
    logic [1:0] loss;
    logic [1:0] state;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sys_rst;
  logic       ready;
  logic       ce_pix;
  logic       ce_48k;
  logic [1:0] lock_loss_cnt;
  logic [1:0] state_o;

  int   checks = 0;
  int   failures = 0;
  exp_t expq[$];

  // Model state: two-deep history of sampled pll_locked, streak of locked FSM samples, loss count.
  logic hist0 = 1'b0;
  logic hist1 = 1'b0;
  int   streak = 0;
  int   loss_model = 0;

  pll_reset_ce_gen #(
    .SYNC_STAGES(2),
    .LOCK_STABLE(L_STABLE),
    .RESET_HOLD (R_HOLD),
    .CE_DIV     (PIX_DIV),
    .AUDIO_DIV  (AUD_DIV),
    .LOSS_W     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .ce_pix       (ce_pix),
    .ce_48k       (ce_48k),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against a bench-computed expectation.
  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance the model by one edge and push the outputs it predicts after that edge.
  task automatic applyStimulus(input logic r, input logic l);
    exp_t e;
    int   run_cycle;
    rst        = r;
    pll_locked = l;
    if (r) begin
      hist0      = 1'b0;
      hist1      = 1'b0;
      streak     = 0;
      loss_model = 0;
    end else begin
      if (hist1) begin
        streak++;
      end else begin
        if (streak >= RUN_K && loss_model < 3) loss_model++;
        streak = 0;
      end
      hist1 = hist0;
      hist0 = l;
    end
    run_cycle = streak - RUN_K;
    if (streak == 0)              e.state = 2'd0;
    else if (streak <= L_STABLE)  e.state = 2'd1;
    else if (streak < RUN_K)      e.state = 2'd2;
    else                          e.state = 2'd3;
    e.ready   = (e.state == 2'd3);
    e.sys_rst = !e.ready;
    e.ce_pix  = e.ready && ((run_cycle % PIX_DIV) == PIX_DIV - 1);
    e.ce_48k  = e.ready && ((run_cycle % AUD_DIV) == AUD_DIV - 1);
    e.loss    = 2'(loss_model);
    expq.push_back(e);
  endtask

  // Pop the oldest prediction and compare it with the DUT outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (expq.size() == 0) begin
      checkValue({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = expq.pop_front();
      checkValue({tag, "_sys_rst"}, int'(sys_rst), int'(e.sys_rst));
      checkValue({tag, "_ready"},   int'(ready),   int'(e.ready));
      checkValue({tag, "_ce_pix"},  int'(ce_pix),  int'(e.ce_pix));
      checkValue({tag, "_ce_48k"},  int'(ce_48k),  int'(e.ce_48k));
      checkValue({tag, "_loss"},    int'(lock_loss_cnt), int'(e.loss));
      checkValue({tag, "_state"},   int'(state_o), int'(e.state));
    end
  endtask

  task automatic step(input logic r, input logic l, input string tag);
    applyStimulus(r, l);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #2;
    // Reset state.
    step(1'b1, 1'b0, "reset");
    step(1'b1, 1'b0, "reset");
    checkValue("reset_state", int'(state_o), 0);
    checkValue("reset_sys_rst", int'(sys_rst), 1);

    // Lock acquisition: edges 0..14 still in reset, edge 15 releases.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "acquire");
    checkValue("edge14_ready", int'(ready), 0);
    checkValue("edge14_sys_rst", int'(sys_rst), 1);
    step(1'b0, 1'b1, "acquire");
    checkValue("edge15_ready", int'(ready), 1);
    checkValue("edge15_sys_rst", int'(sys_rst), 0);
    checkValue("edge15_state", int'(state_o), 3);

    // Clock enables in RUN up to cycle 191 and 383.
    for (int i = 1; i < 191; i++) step(1'b0, 1'b1, "run");
    step(1'b0, 1'b1, "run");
    checkValue("cycle191_ce_pix", int'(ce_pix), 1);
    checkValue("cycle191_ce_48k", int'(ce_48k), 1);
    for (int i = 192; i <= 383; i++) step(1'b0, 1'b1, "run");
    checkValue("cycle383_ce_48k", int'(ce_48k), 1);

    // Lock loss in RUN, then relock.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "loss");
    checkValue("loss_state", int'(state_o), 0);
    checkValue("loss_sys_rst", int'(sys_rst), 1);
    checkValue("loss_count", int'(lock_loss_cnt), 1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, "relock");
    checkValue("relock_ready", int'(ready), 1);
    step(1'b0, 1'b1, "relock");
    step(1'b0, 1'b1, "relock");
    checkValue("relock_cycle2_ce_pix", int'(ce_pix), 0);
    step(1'b0, 1'b1, "relock");
    checkValue("relock_cycle3_ce_pix", int'(ce_pix), 1);

    // Repeated losses saturate the counter.
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "sat_drop");
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, "sat_lock");
    end
    checkValue("loss_saturated", int'(lock_loss_cnt), 3);

    // Reset while in RUN, then reacquire with lock held.
    step(1'b1, 1'b1, "rst_run");
    checkValue("rst_run_loss", int'(lock_loss_cnt), 0);
    checkValue("rst_run_ready", int'(ready), 0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "rst_reacq");
    checkValue("rst_reacq_early", int'(ready), 0);
    step(1'b0, 1'b1, "rst_reacq");
    checkValue("rst_reacq_ready", int'(ready), 1);

    // One-cycle glitch while STABLE with cnt=5 restarts acquisition.
    step(1'b1, 1'b1, "glitch_rst");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "glitch_pre");
    step(1'b0, 1'b0, "glitch");
    step(1'b0, 1'b1, "glitch_relock");
    step(1'b0, 1'b1, "glitch_relock");
    checkValue("glitch_state", int'(state_o), 0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, "glitch_reacq");
    checkValue("glitch_early_ready", int'(ready), 0);
    step(1'b0, 1'b1, "glitch_reacq");
    checkValue("glitch_ready", int'(ready), 1);
    checkValue("glitch_loss", int'(lock_loss_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
